// File: rtl/pipe_pkg.sv
// Shared types for the skid-buffered pipeline stage.
// State encoding and occupancy constants.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_e;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

endpackage

// File: rtl/pipe_entry.sv
// One payload slot: control + data register with valid bit.
// Clear zeroes control and restores the data reset value.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 128,
  parameter logic [DATA_W-1:0] RST_DATA = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic              drop,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              valid,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid  <= 1'b0;
      q_ctrl <= '0;
      q_data <= RST_DATA;
    end else if (clear) begin
      valid  <= 1'b0;
      q_ctrl <= '0;
      q_data <= RST_DATA;
    end else if (load) begin
      valid  <= 1'b1;
      q_ctrl <= d_ctrl;
      q_data <= d_data;
    end else if (drop) begin
      // payload is kept so the data field holds across bubbles
      valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage register with 2-entry skid buffer and flush.
// Optional PIPE_STAGE_PERF_EN adds stall/flush counters.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 128,
  parameter logic [DATA_W-1:0] RST_DATA = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o
`endif
);

  pipe_state_e state, state_n;

  logic              m_valid, s_valid;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl;
  logic [DATA_W-1:0] m_data, s_data;
  logic              m_load, m_drop, m_from_skid;
  logic              s_load, s_drop;
  logic              in_fire, out_fire;
  logic [CTRL_W-1:0] m_d_ctrl;
  logic [DATA_W-1:0] m_d_data;

  assign in_ready_o  = ~s_valid;
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_fire    = out_valid_o & out_ready_i;
  assign out_valid_o = m_valid;
  assign out_ctrl_o  = m_valid ? m_ctrl : '0;
  assign out_data_o  = m_data;

  assign m_d_ctrl = m_from_skid ? s_ctrl : in_ctrl_i;
  assign m_d_data = m_from_skid ? s_data : in_data_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_n;
  end

  always_comb begin
    state_n     = state;
    m_load      = 1'b0;
    m_drop      = 1'b0;
    m_from_skid = 1'b0;
    s_load      = 1'b0;
    s_drop      = 1'b0;
    if (flush_i) begin
      state_n = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            m_load  = 1'b1;
            state_n = FULL;
          end
        end
        FULL: begin
          if (in_fire && out_fire) begin
            m_load = 1'b1;
          end else if (in_fire) begin
            s_load  = 1'b1;
            state_n = SKID;
          end else if (out_fire) begin
            m_drop  = 1'b1;
            state_n = EMPTY;
          end
        end
        SKID: begin
          if (out_fire) begin
            m_load      = 1'b1;
            m_from_skid = 1'b1;
            s_drop      = 1'b1;
            state_n     = FULL;
          end
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  always_comb begin
    occupancy_o = OCC_EMPTY;
    unique case (state)
      FULL:    occupancy_o = OCC_ONE;
      SKID:    occupancy_o = OCC_TWO;
      default: occupancy_o = OCC_EMPTY;
    endcase
  end

  pipe_entry #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .RST_DATA(RST_DATA)
  ) u_main (
    .clk    (clk),
    .rst    (rst),
    .clear  (flush_i),
    .load   (m_load),
    .drop   (m_drop),
    .d_ctrl (m_d_ctrl),
    .d_data (m_d_data),
    .valid  (m_valid),
    .q_ctrl (m_ctrl),
    .q_data (m_data)
  );

  pipe_entry #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .RST_DATA(RST_DATA)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .clear  (flush_i),
    .load   (s_load),
    .drop   (s_drop),
    .d_ctrl (in_ctrl_i),
    .d_data (in_data_i),
    .valid  (s_valid),
    .q_ctrl (s_ctrl),
    .q_data (s_data)
  );

`ifdef PIPE_STAGE_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (out_valid_o && !out_ready_i)
        stall_cnt_o <= stall_cnt_o + 32'd1;
      if (flush_i && occupancy_o != OCC_EMPTY)
        flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Randomized + directed bench for pipe_stage_skid against a queue model.
// Build with PIPE_STAGE_PERF_EN to also check the counters.
module tb_pipe_stage_skid;

  localparam int CW = 16;
  localparam int DW = 32;
  localparam logic [DW-1:0] RD = 32'hDEADBEEF;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occ;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]   stall_cnt;
  logic [31:0]   flush_cnt;
`endif

  pipe_stage_skid #(
    .CTRL_W(CW), .DATA_W(DW), .RST_DATA(RD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_ctrl_i   (in_ctrl),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_ctrl_o  (out_ctrl),
    .out_data_o  (out_data),
    .occupancy_o (occ)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt_o (stall_cnt),
    .flush_cnt_o (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } pl_t;

  pl_t         q[$];
  logic [DW-1:0] hold_d;
  int unsigned m_stall;
  int unsigned m_flush;
  int          tests;
  int          fails;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    hold_d  = RD;
    m_stall = 0;
    m_flush = 0;
  endtask

  task automatic check_all(input string ph);
    int n;
    n = q.size();
    chk({ph, ".valid"}, 64'(out_valid), 64'(n > 0));
    chk({ph, ".ctrl"}, 64'(out_ctrl), (n > 0) ? 64'(q[0].c) : 64'd0);
    chk({ph, ".data"}, 64'(out_data), (n > 0) ? 64'(q[0].d) : 64'(hold_d));
    chk({ph, ".ready"}, 64'(in_ready), 64'(n < 2));
    chk({ph, ".occ"}, 64'(occ), 64'(n));
`ifdef PIPE_STAGE_PERF_EN
    chk({ph, ".stall"}, 64'(stall_cnt), 64'(m_stall));
    chk({ph, ".flushc"}, 64'(flush_cnt), 64'(m_flush));
`endif
  endtask

  // Called at a negedge: drive, advance one edge, update model, check.
  task automatic step(input string ph, input logic f, input logic iv,
                      input logic [CW-1:0] c, input logic [DW-1:0] d,
                      input logic orr);
    bit ifire, ofire;
    pl_t p;
    flush     = f;
    in_valid  = iv;
    in_ctrl   = c;
    in_data   = d;
    out_ready = orr;
    @(posedge clk);
    ifire = iv && (q.size() < 2);
    ofire = (q.size() > 0) && orr;
    if (q.size() > 0 && !orr) m_stall++;
    if (f && q.size() > 0) m_flush++;
    if (f) begin
      q.delete();
      hold_d = RD;
    end else begin
      if (ofire) begin
        p = q.pop_front();
        hold_d = p.d;
      end
      if (ifire) begin
        p.c = c;
        p.d = d;
        q.push_back(p);
      end
    end
    @(negedge clk);
    check_all(ph);
  endtask

  initial begin
    int unsigned s0, f0;
    tests = 0;
    fails = 0;
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_ctrl = '0;
    in_data = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst = 1'b0;
    @(negedge clk);
    check_all("post_reset");

    // streaming at full rate
    for (int i = 1; i <= 8; i++)
      step("stream", 1'b0, 1'b1, CW'(i), $urandom, 1'b1);
    step("stream_drain", 1'b0, 1'b0, '0, '0, 1'b1);

    // back-pressure fills the skid slot
    step("bp1", 1'b0, 1'b1, 16'h00A1, 32'hA1, 1'b0);
    chk("bp_occ1", 64'(occ), 64'd1);
    step("bp2", 1'b0, 1'b1, 16'h00A2, 32'hA2, 1'b0);
    chk("bp_occ2", 64'(occ), 64'd2);
    chk("bp_ready", 64'(in_ready), 64'd0);
    step("bp3", 1'b0, 1'b1, 16'h00A3, 32'hA3, 1'b0);
    chk("bp_hold", 64'(out_ctrl), 64'h00A1);
    step("bp4", 1'b0, 1'b1, 16'h00A3, 32'hA3, 1'b1);
    chk("bp_a2", 64'(out_ctrl), 64'h00A2);
    step("bp5", 1'b0, 1'b1, 16'h00A3, 32'hA3, 1'b1);
    chk("bp_a3", 64'(out_ctrl), 64'h00A3);
    step("bp6", 1'b0, 1'b0, '0, '0, 1'b1);

    // flush while in SKID with an incoming payload
    step("fl1", 1'b0, 1'b1, 16'h00B1, 32'hB1, 1'b0);
    step("fl2", 1'b0, 1'b1, 16'h00B2, 32'hB2, 1'b0);
    step("fl3", 1'b1, 1'b1, 16'h00FF, 32'hFF, 1'b0);
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_ctrl", 64'(out_ctrl), 64'd0);
    chk("fl_occ", 64'(occ), 64'd0);
    chk("fl_ready", 64'(in_ready), 64'd1);
    chk("fl_data", 64'(out_data), 64'(RD));
    repeat (2) step("fl_after", 1'b0, 1'b0, '0, '0, 1'b1);

    // bubble between payloads
    step("bub1", 1'b0, 1'b1, 16'h00C1, 32'hC1, 1'b1);
    repeat (3) begin
      step("bub_gap", 1'b0, 1'b0, 16'h7777, 32'h7777, 1'b1);
      chk("bub_data", 64'(out_data), 64'hC1);
    end
    step("bub2", 1'b0, 1'b1, 16'h00C2, 32'hC2, 1'b1);
    step("bub3", 1'b0, 1'b0, '0, '0, 1'b1);

    // async reset in the middle of a cycle
    step("ar1", 1'b0, 1'b1, 16'h00D1, 32'hD1, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", 64'(out_valid), 64'd0);
    chk("ar_ctrl", 64'(out_ctrl), 64'd0);
    chk("ar_data", 64'(out_data), 64'(RD));
    chk("ar_occ", 64'(occ), 64'd0);
    chk("ar_ready", 64'(in_ready), 64'd1);
    model_reset();
    #1 rst = 1'b0;
    step("ar2", 1'b0, 1'b0, '0, '0, 1'b0);

`ifdef PIPE_STAGE_PERF_EN
    s0 = stall_cnt;
    f0 = flush_cnt;
    step("pf1", 1'b0, 1'b1, 16'h00E1, 32'hE1, 1'b0);
    step("pf2", 1'b0, 1'b1, 16'h00E2, 32'hE2, 1'b0);
    repeat (4) step("pf_hold", 1'b0, 1'b0, '0, '0, 1'b0);
    step("pf_flush", 1'b1, 1'b0, '0, '0, 1'b1);
    chk("pf_stall5", 64'(stall_cnt - s0), 64'd5);
    chk("pf_flush1", 64'(flush_cnt - f0), 64'd1);
`else
    s0 = 0;
    f0 = s0;
`endif

    // random traffic
    for (int i = 0; i < 3000; i++)
      step("rand", ($urandom_range(99) < 4), ($urandom_range(99) < 70),
           CW'($urandom), $urandom, ($urandom_range(99) < 60));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
